// File: rtl/bp_clint_cmd_arbiter.sv
// rtl/bp_clint_cmd_arbiter.sv - two-source round-robin command merge into CLINT with in-order response return
// Source ids of accepted commands queue in order so each CLINT response returns to the requester that issued it.
module bp_clint_cmd_arbiter #(
  parameter  int msg_width_p       = 576,
  parameter  int max_outstanding_p = 2,
  localparam int cnt_width_lp      = $clog2(max_outstanding_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,

  input  logic [msg_width_p-1:0]  mem_cmd0_i,
  input  logic                    mem_cmd0_v_i,
  output logic                    mem_cmd0_ready_o,
  input  logic [msg_width_p-1:0]  mem_cmd1_i,
  input  logic                    mem_cmd1_v_i,
  output logic                    mem_cmd1_ready_o,

  output logic [msg_width_p-1:0]  mem_cmd_o,
  output logic                    mem_cmd_v_o,
  input  logic                    mem_cmd_ready_i,

  input  logic [msg_width_p-1:0]  mem_resp_i,
  input  logic                    mem_resp_v_i,
  output logic                    mem_resp_yumi_o,

  output logic [msg_width_p-1:0]  mem_resp0_o,
  output logic                    mem_resp0_v_o,
  input  logic                    mem_resp0_yumi_i,
  output logic [msg_width_p-1:0]  mem_resp1_o,
  output logic                    mem_resp1_v_o,
  input  logic                    mem_resp1_yumi_i,

  output logic [cnt_width_lp-1:0] outstanding_o,
  output logic                    resp_err_o
);

  localparam int ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(max_outstanding_p - 1);
  localparam logic [cnt_width_lp-1:0] cnt_max_lp  = cnt_width_lp'(max_outstanding_p);

  logic                         r_ptr;
  logic [max_outstanding_p-1:0] r_tags;
  logic [ptr_width_lp-1:0]      r_wr_ptr;
  logic [ptr_width_lp-1:0]      r_rd_ptr;
  logic [cnt_width_lp-1:0]      r_cnt;
  logic                         r_err;

  logic w_full;
  logic w_empty;
  logic w_any_v;
  logic w_gnt1;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_resp0_v;
  logic w_resp1_v;
  logic [ptr_width_lp-1:0] w_wr_ptr_nxt;
  logic [ptr_width_lp-1:0] w_rd_ptr_nxt;

  assign w_full  = (r_cnt == cnt_max_lp);
  assign w_empty = (r_cnt == '0);
  assign w_any_v = mem_cmd0_v_i | mem_cmd1_v_i;

  // r_ptr=0 favours source 0 when both request; a lone requester always wins.
  assign w_gnt1 = mem_cmd1_v_i & (~mem_cmd0_v_i | r_ptr);

  assign mem_cmd_o        = w_gnt1 ? mem_cmd1_i : mem_cmd0_i;
  assign mem_cmd_v_o      = reset_n_i & w_any_v & ~w_full;
  assign mem_cmd0_ready_o = reset_n_i & w_any_v & ~w_gnt1 & mem_cmd_ready_i & ~w_full;
  assign mem_cmd1_ready_o = reset_n_i & w_gnt1 & mem_cmd_ready_i & ~w_full;

  assign w_push = mem_cmd_v_o & mem_cmd_ready_i;

  assign w_head    = r_tags[r_rd_ptr];
  assign w_resp0_v = reset_n_i & mem_resp_v_i & ~w_empty & ~w_head;
  assign w_resp1_v = reset_n_i & mem_resp_v_i & ~w_empty &  w_head;

  assign mem_resp0_o     = mem_resp_i;
  assign mem_resp1_o     = mem_resp_i;
  assign mem_resp0_v_o   = w_resp0_v;
  assign mem_resp1_v_o   = w_resp1_v;
  assign mem_resp_yumi_o = (w_resp0_v & mem_resp0_yumi_i) | (w_resp1_v & mem_resp1_yumi_i);

  assign w_pop = mem_resp_yumi_o;

  assign w_wr_ptr_nxt = (r_wr_ptr == ptr_last_lp) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == ptr_last_lp) ? '0 : r_rd_ptr + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_ptr    <= 1'b0;
      r_tags   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_tags[r_wr_ptr] <= w_gnt1;
        r_wr_ptr         <= w_wr_ptr_nxt;
        r_ptr            <= ~r_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + cnt_width_lp'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - cnt_width_lp'(1);
      end
      // A response with nothing outstanding cannot be matched to a requester; latch it until reset.
      if (mem_resp_v_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding_o = r_cnt;
  assign resp_err_o    = r_err;

endmodule
